// File: rtl/vu_bar_ctrl_if.sv
// ---------------------------------------------------------------------------
// vu_bar_ctrl_if
// Level-sample handshake between an audio level source and the VU-meter bar
// controller.
//   level_in    : sample level, 0..2^LW-1 segments
//   level_ch    : target channel of the sample (0 or 1)
//   level_valid : source offers a sample
//   level_ready : controller accepts when level_valid & level_ready
// The master modport is the level source, the slave modport the controller.
// ---------------------------------------------------------------------------
interface vu_bar_ctrl_if #(
    parameter int LW = 4
);
    logic [LW-1:0] level_in;
    logic          level_ch;
    logic          level_valid;
    logic          level_ready;

    modport master (
        output level_in,
        output level_ch,
        output level_valid,
        input  level_ready
    );

    modport slave (
        input  level_in,
        input  level_ch,
        input  level_valid,
        output level_ready
    );
endinterface

// File: rtl/vu_bar_ctrl.sv
// ---------------------------------------------------------------------------
// vu_bar_ctrl
// Two-channel VU-meter bar renderer for the vga timing generator. Level
// samples arrive on a valid/ready handshake and land in shadow registers.
// On each frame_start both channels are committed to the active registers
// together, so a bar never changes in the middle of a frame. Each channel
// also keeps a peak-hold marker that is held for HOLD_FRAMES frames and then
// decays one segment per frame towards the current level.
//
// Ports
//   pixel_clock : pixel clock, all logic on the rising edge
//   reset       : asynchronous active-low reset (0 = reset)
//   lvl         : level handshake (level_in, level_ch, level_valid, level_ready)
//   frame_start : one-cycle pulse at the first pixel of vertical blanking
//   video_on    : high inside the addressable area
//   h_count     : current pixel column
//   v_count     : current line
//   red/green/blue : registered pixel colour, one cycle after the counters
// ---------------------------------------------------------------------------
module vu_bar_ctrl #(
    parameter int CW          = 10,
    parameter int LW          = 4,
    parameter int SEG_SHIFT   = 5,
    parameter int BAR_H       = 64,
    parameter int BAR0_Y      = 100,
    parameter int BAR1_Y      = 300,
    parameter int GREEN_SEGS  = 10,
    parameter int RED_START   = 13,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                pixel_clock,
    input  logic                reset,
    vu_bar_ctrl_if.slave        lvl,
    input  logic                frame_start,
    input  logic                video_on,
    input  logic [CW-1:0]       h_count,
    input  logic [CW-1:0]       v_count,
    output logic [2:0]          red,
    output logic [2:0]          green,
    output logic [1:0]          blue
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    // Render comparisons are done on 32-bit values so that neither the
    // segment index nor the bar row limits are ever truncated.
    localparam logic [31:0] NSEG    = 32'(1 << LW);
    localparam logic [31:0] ROW0_LO = 32'(BAR0_Y);
    localparam logic [31:0] ROW0_HI = 32'(BAR0_Y + BAR_H);
    localparam logic [31:0] ROW1_LO = 32'(BAR1_Y);
    localparam logic [31:0] ROW1_HI = 32'(BAR1_Y + BAR_H);
    localparam logic [31:0] GSEGS   = 32'(GREEN_SEGS);
    localparam logic [31:0] RSTART  = 32'(RED_START);

    localparam logic [7:0] COL_BLACK  = 8'b000_000_00;
    localparam logic [7:0] COL_GREEN  = 8'b000_111_00;
    localparam logic [7:0] COL_YELLOW = 8'b111_111_00;
    localparam logic [7:0] COL_RED    = 8'b111_000_00;
    localparam logic [7:0] COL_WHITE  = 8'b111_111_11;
    localparam logic [7:0] COL_DIM    = 8'b000_001_00;

    logic                   readyEn_q;
    logic [1:0][LW-1:0]     shadow_q, shadow_d;
    logic [1:0][LW-1:0]     active_q, active_d;
    logic [1:0][LW-1:0]     peak_q,   peak_d;
    logic [1:0][HW-1:0]     hold_q,   hold_d;
    logic [7:0]             colour_q, colour_d;

    logic                   accept;
    logic                   row0, row1;
    logic [31:0]            vExt, segExt;
    logic [LW-1:0]          selActive, selPeak;

    // readyEn_q keeps level_ready low while in reset and rises on the first
    // clock after release; the commit cycle always blocks a handshake.
    assign lvl.level_ready = readyEn_q & ~frame_start;
    assign accept          = lvl.level_valid & lvl.level_ready;

    // Next-state for the level registers: accepts write the shadow, and a
    // frame_start commits both channels and steps the peak-hold logic.
    // Accept and commit never coincide because ready is low at commit.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        peak_d   = peak_q;
        hold_d   = hold_q;
        if (accept) begin
            shadow_d[lvl.level_ch] = lvl.level_in;
        end
        if (frame_start) begin
            for (int c = 0; c < 2; c++) begin
                active_d[c] = shadow_q[c];
                if (shadow_q[c] >= peak_q[c]) begin
                    peak_d[c] = shadow_q[c];
                    hold_d[c] = HW'(HOLD_FRAMES);
                end else if (hold_q[c] != '0) begin
                    hold_d[c] = hold_q[c] - HW'(1);
                end else begin
                    // peak > level here, so one step down never passes it
                    peak_d[c] = peak_q[c] - LW'(1);
                end
            end
        end
    end

    assign vExt   = 32'(v_count);
    assign segExt = 32'(h_count >> SEG_SHIFT);
    assign row0   = (vExt >= ROW0_LO) && (vExt < ROW0_HI);
    assign row1   = (vExt >= ROW1_LO) && (vExt < ROW1_HI);
    assign selActive = row0 ? active_q[0] : active_q[1];
    assign selPeak   = row0 ? peak_q[0]   : peak_q[1];

    // Pixel colour for the current counters; the peak marker wins over the
    // bar, and anything right of the last possible segment stays black.
    always_comb begin
        colour_d = COL_BLACK;
        if (video_on && (row0 || row1)) begin
            if (segExt >= NSEG) begin
                colour_d = COL_BLACK;
            end else if ((selPeak != '0) && (segExt == (32'(selPeak) - 32'd1))) begin
                colour_d = COL_WHITE;
            end else if (segExt < 32'(selActive)) begin
                if (segExt < GSEGS) begin
                    colour_d = COL_GREEN;
                end else if (segExt < RSTART) begin
                    colour_d = COL_YELLOW;
                end else begin
                    colour_d = COL_RED;
                end
            end else begin
                colour_d = COL_DIM;
            end
        end
    end

    // State and colour registers; reset blanks the screen immediately.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            readyEn_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            peak_q    <= '0;
            hold_q    <= '0;
            colour_q  <= '0;
        end else begin
            readyEn_q <= 1'b1;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            peak_q    <= peak_d;
            hold_q    <= hold_d;
            colour_q  <= colour_d;
        end
    end

    assign red   = colour_q[7:5];
    assign green = colour_q[4:2];
    assign blue  = colour_q[1:0];
endmodule

// File: tb/tb_vu_bar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vu_bar_ctrl
// Directed bench for vu_bar_ctrl (HOLD_FRAMES = 2, other parameters default).
// Pixel probes push the hand-computed colour into a scoreboard queue; a
// monitor pops and compares one cycle later when the registered colour is
// presented. Handshake and reset checks are made directly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vu_bar_ctrl;
    localparam int CW = 10;
    localparam int LW = 4;

    localparam logic [7:0] BLACK  = 8'b000_000_00;
    localparam logic [7:0] GREEN  = 8'b000_111_00;
    localparam logic [7:0] YELLOW = 8'b111_111_00;
    localparam logic [7:0] RED    = 8'b111_000_00;
    localparam logic [7:0] WHITE  = 8'b111_111_11;
    localparam logic [7:0] DIM    = 8'b000_001_00;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } expect_t;

    logic          pixel_clock = 1'b0;
    logic          reset       = 1'b0;
    logic          frame_start = 1'b0;
    logic          video_on    = 1'b0;
    logic [CW-1:0] h_count     = '0;
    logic [CW-1:0] v_count     = '0;
    logic [2:0]    red, green;
    logic [1:0]    blue;

    int      assertCount = 0;
    int      failCount   = 0;
    bit      probe       = 1'b0;
    bit      probeDly    = 1'b0;
    expect_t scoreQ[$];

    vu_bar_ctrl_if #(.LW(LW)) lvl ();

    vu_bar_ctrl #(
        .HOLD_FRAMES(2)
    ) dut (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .lvl(lvl),
        .frame_start(frame_start),
        .video_on(video_on),
        .h_count(h_count),
        .v_count(v_count),
        .red(red),
        .green(green),
        .blue(blue)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Compare one value and keep the running counts.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // A probe driven in one cycle is registered at the next rising edge.
    always @(posedge pixel_clock) probeDly <= probe;

    // Scoreboard monitor: the registered colour is compared mid-cycle.
    always @(negedge pixel_clock) begin
        if (probeDly) begin
            if (scoreQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL scoreboard underflow: colour %b with nothing expected",
                         {red, green, blue});
            end else begin
                expect_t e;
                e = scoreQ.pop_front();
                checkOutput(e.name, {red, green, blue}, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    // Drive one pixel and queue the colour it must produce.
    task automatic applyStimulus(input string name, input int h, input int v,
                                 input logic von, input logic [7:0] exp);
        expect_t e;
        h_count  = CW'(h);
        v_count  = CW'(v);
        video_on = von;
        probe    = 1'b1;
        e.name   = name;
        e.exp    = exp;
        scoreQ.push_back(e);
        tick();
        probe = 1'b0;
    endtask

    task automatic scanSeg(input string name, input int seg, input int v,
                           input logic [7:0] exp);
        applyStimulus($sformatf("%s seg%0d row%0d", name, seg, v), seg * 32 + 7, v, 1'b1, exp);
    endtask

    task automatic sendLevel(input logic ch, input int lvlVal);
        bit done = 1'b0;
        lvl.level_ch    = ch;
        lvl.level_in    = LW'(lvlVal);
        lvl.level_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge pixel_clock);
            if (lvl.level_ready) begin
                tick();
                done = 1'b1;
            end
        end
        lvl.level_valid = 1'b0;
        if (!done) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL handshake timeout: ch%0d level %0d never accepted", ch, lvlVal);
            tick();
        end
    endtask

    task automatic frameStart();
        video_on    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expPeak[9] = '{8, 8, 7, 6, 5, 4, 3, 3, 3};
        lvl.level_valid = 1'b0;
        lvl.level_ch    = 1'b0;
        lvl.level_in    = '0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            lvl.level_valid = 1'($urandom_range(0, 1));
            lvl.level_ch    = 1'($urandom_range(0, 1));
            lvl.level_in    = LW'($urandom_range(0, 15));
            frame_start     = 1'($urandom_range(0, 1));
            video_on        = 1'b1;
            h_count         = CW'($urandom_range(0, 300));
            v_count         = CW'(100 + $urandom_range(0, 63));
            @(negedge pixel_clock);
            checkOutput("reset colour", {red, green, blue}, BLACK);
            checkOutput("reset ready", {7'b0, lvl.level_ready}, 8'd0);
            tick();
        end
        lvl.level_valid = 1'b0;
        frame_start     = 1'b0;
        video_on        = 1'b0;
        reset           = 1'b1;
        @(negedge pixel_clock);
        checkOutput("ready before first clock", {7'b0, lvl.level_ready}, 8'd0);
        @(negedge pixel_clock);
        checkOutput("ready after release", {7'b0, lvl.level_ready}, 8'd1);
        tick();

        // Idle bars after reset: background only, no marker anywhere
        scanSeg("idle ch0", 0, 100, DIM);
        scanSeg("idle ch1 no marker", 15, 300, DIM);
        applyStimulus("video off", 7, 100, 1'b0, BLACK);
        scanSeg("outside rows", 0, 50, BLACK);

        // Commit ch0 = 5
        sendLevel(1'b0, 5);
        scanSeg("pre-commit", 0, 100, DIM);
        frameStart();
        for (int s = 0; s < 8; s++) begin
            scanSeg("commit5", s, 100, (s < 4) ? GREEN : (s == 4) ? WHITE : DIM);
        end
        scanSeg("commit5 last line", 0, 163, GREEN);
        scanSeg("below bar0", 0, 164, BLACK);
        scanSeg("above bar0", 0, 99, BLACK);
        scanSeg("ch1 empty", 0, 300, DIM);

        // Tear-free update to 12
        sendLevel(1'b0, 12);
        scanSeg("tear", 3, 100, GREEN);
        scanSeg("tear", 4, 100, WHITE);
        scanSeg("tear", 5, 100, DIM);
        frameStart();
        scanSeg("commit12", 4, 100, GREEN);
        scanSeg("commit12", 9, 100, GREEN);
        scanSeg("commit12", 10, 100, YELLOW);
        scanSeg("commit12", 11, 100, WHITE);
        scanSeg("commit12", 12, 100, DIM);
        scanSeg("commit12", 10, 163, YELLOW);

        // Valid held across the commit cycle
        lvl.level_ch    = 1'b1;
        lvl.level_in    = LW'(15);
        lvl.level_valid = 1'b1;
        frame_start     = 1'b1;
        @(negedge pixel_clock);
        checkOutput("collision ready", {7'b0, lvl.level_ready}, 8'd0);
        tick();
        frame_start = 1'b0;
        @(negedge pixel_clock);
        checkOutput("post-collision ready", {7'b0, lvl.level_ready}, 8'd1);
        tick();
        lvl.level_valid = 1'b0;
        scanSeg("collision not yet visible", 0, 300, DIM);
        frameStart();
        scanSeg("ch1=15", 9, 300, GREEN);
        scanSeg("ch1=15", 10, 300, YELLOW);
        scanSeg("ch1=15", 12, 300, YELLOW);
        scanSeg("ch1=15", 13, 300, RED);
        scanSeg("ch1=15", 14, 300, WHITE);
        scanSeg("ch1=15", 15, 300, DIM);
        scanSeg("ch1=15 beyond", 16, 300, BLACK);
        scanSeg("ch1=15 far", 31, 300, BLACK);
        scanSeg("ch1=15 last line", 13, 363, RED);
        scanSeg("below bar1", 13, 364, BLACK);
        scanSeg("ch0 still", 11, 100, WHITE);

        // Reset asserted mid-frame blanks at once
        h_count  = CW'(7);
        v_count  = CW'(100);
        video_on = 1'b1;
        tick();
        @(negedge pixel_clock);
        checkOutput("pre-reset pixel", {red, green, blue}, GREEN);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset colour", {red, green, blue}, BLACK);
        checkOutput("async reset ready", {7'b0, lvl.level_ready}, 8'd0);
        tick();
        reset = 1'b1;
        tick();
        scanSeg("after reset ch0", 0, 100, DIM);
        scanSeg("after reset ch1", 13, 300, DIM);

        // Peak hold then decay (HOLD_FRAMES = 2)
        sendLevel(1'b0, 8);
        frameStart();
        scanSeg("peak8", 7, 100, WHITE);
        scanSeg("peak8", 8, 100, DIM);
        scanSeg("peak8", 0, 100, GREEN);
        for (int f = 0; f < 9; f++) begin
            sendLevel(1'b0, 3);
            frameStart();
            scanSeg($sformatf("decay f%0d marker", f), expPeak[f] - 1, 100, WHITE);
            scanSeg($sformatf("decay f%0d above", f), expPeak[f], 100, DIM);
        end
        scanSeg("decay level", 0, 100, GREEN);

        // Drain the scoreboard
        for (int i = 0; i < 10 && scoreQ.size() != 0; i++) tick();
        tick();
        if (scoreQ.size() != 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard drain: %0d left, expected 0", scoreQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
